// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - opcode encodings OP_ADD .. OP_NOT, with OP_LAST marking the highest legal opcode
//   - state_t: sequencer FSM states (IDLE -> EXEC -> RESP)
package alu_pkg;

    localparam int unsigned DATA_W_DEFAULT = 16;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL5  = 4'd2;
    localparam logic [3:0] OP_DIV10 = 4'd3;
    localparam logic [3:0] OP_INC   = 4'd4;
    localparam logic [3:0] OP_DEC   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_LAST  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core16.sv
// alu_core16: purely combinational signed ALU datapath.
// Ports:
//   opcode      in   4       operation select (0..OP_LAST legal)
//   a, b        in   DATA_W  two's-complement operands
//   result      out  DATA_W  low DATA_W bits of the true result
//   ovf         out  1       true signed result not representable in DATA_W
//   err         out  1       illegal opcode (result forced to 0)
module alu_core16
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic              err
);

    localparam logic [DATA_W-1:0]        SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]        SMIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] TEN  = DATA_W'(10);

    logic [DATA_W-1:0]        sum;
    logic [DATA_W-1:0]        diff;
    logic [DATA_W-1:0]        quot;
    logic signed [DATA_W+2:0] ax;
    logic signed [DATA_W+2:0] prod;
    logic [3:0]               prod_top;

    assign sum  = a + b;
    assign diff = a - b;
    // Signed division truncates toward zero, matching the required /10 rounding.
    assign quot = $signed(a) / TEN;

    // A*5 as (A<<2)+A in DATA_W+3 bits, wide enough to hold the full product.
    assign ax       = {{3{a[DATA_W-1]}}, a};
    assign prod     = (ax <<< 2) + ax;
    assign prod_top = prod[DATA_W+2:DATA_W-1];

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum;
                ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_MUL5: begin
                result = prod[DATA_W-1:0];
                // In range only if the top bits are pure sign extension.
                ovf    = (prod_top != '0) && (prod_top != '1);
            end
            OP_DIV10: result = quot;
            OP_INC: begin
                result = a + 1'b1;
                ovf    = (a == SMAX);
            end
            OP_DEC: begin
                result = a - 1'b1;
                ovf    = (a == SMIN);
            end
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter/sequencer for one shared ALU.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake, N = 0/1 (ready is combinational, IDLE only)
//   reqN_opcode/a/b          operation, sampled only at acceptance
//   rspN_valid/ready         response handshake for the transaction owner
//   rsp_result/ovf/err       registered result and flags, shared by both ports
//   ovf_sticky/ovf_clr       per-requester sticky overflow and clear
// Build option: define ALU_ARB_STICKY_OVF_EN to enable ovf_sticky; otherwise it
// reads 0 and ovf_clr is ignored.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_ovf,
    output logic              rsp_err,
    output logic [1:0]        ovf_sticky,
    input  logic [1:0]        ovf_clr
);

    state_t            state;
    state_t            state_nxt;
    logic              prio;
    logic              owner;
    logic              winner;
    logic              grant;
    logic              rsp_hs;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] core_result;
    logic              core_ovf;
    logic              core_err;

    // A lone requester always wins; prio only breaks ties.
    assign grant  = req0_valid | req1_valid;
    assign winner = (req0_valid & req1_valid) ? prio : req1_valid;
    assign rsp_hs = (state == ST_RESP) && (owner ? rsp1_ready : rsp0_ready);

    alu_core16 #(.DATA_W(DATA_W)) u_core (
        .opcode (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result),
        .ovf    (core_ovf),
        .err    (core_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_hs) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                // Masked during reset so nothing appears accepted on a reset edge.
                if (!rst) begin
                    req0_ready = req0_valid & ~winner;
                    req1_ready = req1_valid & winner;
                end
            end
            ST_RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio       <= 1'b0;
            owner      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == ST_IDLE && grant) begin
                owner <= winner;
                op_q  <= winner ? req1_opcode : req0_opcode;
                a_q   <= winner ? req1_a : req0_a;
                b_q   <= winner ? req1_b : req0_b;
            end
            if (state == ST_EXEC) begin
                rsp_result <= core_result;
                rsp_ovf    <= core_ovf;
                rsp_err    <= core_err;
            end
            if (rsp_hs) begin
                prio <= ~owner;
            end
        end
    end

`ifdef ALU_ARB_STICKY_OVF_EN
    logic [1:0] sticky_set;

    always_comb begin
        sticky_set = '0;
        if (rsp_hs && rsp_ovf) begin
            sticky_set[owner] = 1'b1;
        end
    end

    // Set is OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= '0;
        end else begin
            ovf_sticky <= (ovf_sticky & ~ovf_clr) | sticky_set;
        end
    end
`else
    logic [1:0] unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_sticky     = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural
// integer reference model and directed plus randomized scenarios.
module tb_alu_arbiter;

    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [3:0]        req0_opcode = '0, req1_opcode = '0;
    logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_ovf, rsp_err;
    logic [1:0]        ovf_sticky;
    logic [1:0]        ovf_clr = '0;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer arithmetic, then range test and truncation.
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output logic ovf, output logic err);
        int sa, sb, full;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        err = 1'b0;
        case (op)
            4'd0: full = sa + sb;
            4'd1: full = sa - sb;
            4'd2: full = sa * 5;
            4'd3: full = sa / 10;
            4'd4: full = sa + 1;
            4'd5: full = sa - 1;
            4'd6: full = int'($signed(a & b));
            4'd7: full = int'($signed(a ^ b));
            4'd8: full = int'($signed(a | b));
            4'd9: full = int'($signed(~a));
            default: begin full = 0; err = 1'b1; end
        endcase
        ovf = (full > 32767) || (full < -32768);
        res = full[15:0];
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        ovf_clr = '0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) at negedges for a port's rsp_valid; samples counts the negedges taken.
    task automatic wait_rsp(input int port, output int samples, output bit tout);
        samples = 0;
        tout    = 1'b0;
        while (!(port == 0 ? rsp0_valid : rsp1_valid)) begin
            @(negedge clk);
            samples++;
            if (samples > 20) begin tout = 1'b1; break; end
        end
    endtask

    // Drives one transaction alone on a port and collects the response.
    // lat = negedges sampled after the accepting edge until rsp valid (2 expected).
    task automatic run_txn(input int port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic ovf, output logic err,
                           output int lat, output bit tout);
        int n;
        tout = 1'b0; lat = 0; res = '0; ovf = 1'b0; err = 1'b0;
        @(negedge clk);
        if (port == 0) begin
            req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
            rsp1_ready = 1'($urandom_range(0, 1));
        end else begin
            req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
            rsp0_ready = 1'($urandom_range(0, 1));
        end
        #1;
        n = 0;
        while (!(port == 0 ? req0_ready : req1_ready)) begin
            @(negedge clk); #1;
            n++;
            if (n > 20) begin tout = 1'b1; break; end
        end
        if (!tout) begin
            @(negedge clk);
            // Scramble fields after acceptance; the DUT must have already latched them.
            if (port == 0) begin
                req0_valid = 1'b0; req0_opcode = 4'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom);
            end else begin
                req1_valid = 1'b0; req1_opcode = 4'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
            end
            wait_rsp(port, lat, tout);
            lat = lat + 1;
            res = rsp_result; ovf = rsp_ovf; err = rsp_err;
            if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_masked: req0_ready=%b required 0", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_ovf, rsp_err, ovf_sticky} !== 8'h00 ||
                rsp_result !== 16'h0000) begin
                errors++;
                $display("FAIL reset_idle[%0d]: rdy=%b%b vld=%b%b res=%h ovf=%b err=%b sticky=%b required all 0",
                         i, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_ovf, rsp_err, ovf_sticky);
            end
        end
    endtask

    task automatic test_add_overflow();
        logic [15:0] res; logic ovf, err; int lat; bit tout;
        run_txn(0, 4'd0, 16'h7FFF, 16'h0001, res, ovf, err, lat, tout);
        checks++;
        if (tout || lat != 2) begin
            errors++; $display("FAIL add_ovf_latency: lat=%0d tout=%0b required lat=2", lat, tout);
        end
        checks++;
        if (res !== 16'h8000 || ovf !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL add_ovf_result: res=%h ovf=%b err=%b required 8000 1 0", res, ovf, err);
        end
    endtask

    task automatic test_simultaneous();
        int s; bit tout;
        do_reset(2);
        @(negedge clk);
        req0_opcode = 4'd2; req0_a = 16'd7;     req0_b = 16'd0; req0_valid = 1'b1;
        req1_opcode = 4'd3; req1_a = 16'hFFE7;  req1_b = 16'd0; req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL simul_first_grant: rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp(0, s, tout);
        checks++;
        if (tout || rsp_result !== 16'd35 || rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL simul_rsp0: res=%h vld1=%b tout=%0b required 0023 0", rsp_result, rsp1_valid, tout);
        end
        // Re-request on port 0 while port 1 still waits; port 1 must now win.
        req0_opcode = 4'd4; req0_a = 16'd10; req0_valid = 1'b1;
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL simul_no_ready_in_resp: rdy0=%b rdy1=%b required 0 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL simul_rr_grant: rdy0=%b rdy1=%b required 0 1", req0_ready, req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(1, s, tout);
        checks++;
        if (tout || rsp_result !== 16'hFFFE || rsp_ovf !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL simul_rsp1: res=%h ovf=%b vld0=%b tout=%0b required fffe 0 0", rsp_result, rsp_ovf, rsp0_valid, tout);
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL simul_back_to_0: rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(0, s, tout);
        checks++;
        if (tout || rsp_result !== 16'd11) begin
            errors++; $display("FAIL simul_rsp0_inc: res=%h tout=%0b required 000b", rsp_result, tout);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
    endtask

    task automatic test_illegal_and_not();
        logic [15:0] res; logic ovf, err; int lat; bit tout;
        run_txn(1, 4'd12, 16'h1234, 16'h5678, res, ovf, err, lat, tout);
        checks++;
        if (tout || res !== 16'h0000 || err !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL illegal_op: res=%h ovf=%b err=%b tout=%0b required 0000 0 1", res, ovf, err, tout);
        end
        run_txn(1, 4'd9, 16'h0000, 16'h0000, res, ovf, err, lat, tout);
        checks++;
        if (tout || res !== 16'hFFFF || err !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL not_zero: res=%h ovf=%b err=%b tout=%0b required ffff 0 0", res, ovf, err, tout);
        end
    endtask

    task automatic test_backpressure();
        int s; bit tout;
        logic [15:0] exp_res; logic exp_ovf, exp_err;
        model(4'd0, 16'd100, 16'hFED4, exp_res, exp_ovf, exp_err);
        @(negedge clk);
        req0_opcode = 4'd0; req0_a = 16'd100; req0_b = 16'hFED4; req0_valid = 1'b1;
        #1;
        s = 0;
        while (!req0_ready && s < 20) begin @(negedge clk); #1; s++; end
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL bp_accept: req0_ready=%b required 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_opcode = 4'd1; req1_a = 16'd3; req1_b = 16'd1; req1_valid = 1'b1;
        wait_rsp(0, s, tout);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (tout || rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== exp_res ||
                rsp_ovf !== exp_ovf || rsp_err !== exp_err || req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b%b res=%h ovf=%b err=%b rdy1=%b required vld0=1 res=%h ovf=%b err=%b rdy1=0",
                         i, rsp0_valid, rsp1_valid, rsp_result, rsp_ovf, rsp_err, req1_ready, exp_res, exp_ovf, exp_err);
            end
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: rdy1=%b vld0=%b required 1 0", req1_ready, rsp0_valid);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [15:0] res; logic ovf, err; int lat; bit tout;
        do_reset(2);
        run_txn(0, 4'd0, 16'd1, 16'd2, res, ovf, err, lat, tout);
        checks++;
        if (tout || res !== 16'd3) begin
            errors++; $display("FAIL abort_pre_txn: res=%h tout=%0b required 0003", res, tout);
        end
        @(negedge clk);
        req1_opcode = 4'd0; req1_a = 16'd5; req1_b = 16'd5; req1_valid = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL abort_accept1: req1_ready=%b required 1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                errors++; $display("FAIL abort_no_rsp[%0d]: vld0=%b vld1=%b required 0 0", i, rsp0_valid, rsp1_valid);
            end
            @(negedge clk);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL abort_prio_reset: rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] a, b, res, exp_res; logic [3:0] op; logic ovf, err, exp_ovf, exp_err;
        logic [1:0] exp_sticky;
        int lat, port; bit tout;
        logic [15:0] edges [5];
        edges[0] = 16'h7FFF; edges[1] = 16'h8000; edges[2] = 16'hFFFF; edges[3] = 16'h0000; edges[4] = 16'h0001;
        do_reset(2);
        exp_sticky = '0;
        for (int i = 0; i < 60; i++) begin
            port = int'($urandom_range(0, 1));
            op   = 4'($urandom_range(0, 15));
            a    = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 16'($urandom);
            b    = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 16'($urandom);
            model(op, a, b, exp_res, exp_ovf, exp_err);
            run_txn(port, op, a, b, res, ovf, err, lat, tout);
            if (exp_ovf) exp_sticky[port] = 1'b1;
            checks++;
            if (tout || lat != 2) begin
                errors++; $display("FAIL rand_latency[%0d]: lat=%0d tout=%0b required 2", i, lat, tout);
            end
            checks++;
            if (res !== exp_res || ovf !== exp_ovf || err !== exp_err) begin
                errors++;
                $display("FAIL rand_result[%0d]: port=%0d op=%0d a=%h b=%h got res=%h ovf=%b err=%b required res=%h ovf=%b err=%b",
                         i, port, op, a, b, res, ovf, err, exp_res, exp_ovf, exp_err);
            end
        end
`ifndef ALU_ARB_STICKY_OVF_EN
        exp_sticky = '0;
`endif
        checks++;
        if (ovf_sticky !== exp_sticky) begin
            errors++; $display("FAIL rand_sticky: ovf_sticky=%b required %b", ovf_sticky, exp_sticky);
        end
    endtask

    task automatic test_sticky();
        logic [15:0] res; logic ovf, err; int lat; bit tout;
        do_reset(2);
        run_txn(0, 4'd5, 16'h8000, 16'h0000, res, ovf, err, lat, tout);
        checks++;
        if (tout || res !== 16'h7FFF || ovf !== 1'b1) begin
            errors++; $display("FAIL sticky_dec_min: res=%h ovf=%b tout=%0b required 7fff 1", res, ovf, tout);
        end
        #1;
`ifdef ALU_ARB_STICKY_OVF_EN
        checks++;
        if (ovf_sticky !== 2'b01) begin
            errors++; $display("FAIL sticky_set: ovf_sticky=%b required 01", ovf_sticky);
        end
        @(negedge clk);
        ovf_clr = 2'b10;
        @(negedge clk);
        checks++;
        if (ovf_sticky !== 2'b01) begin
            errors++; $display("FAIL sticky_other_clr: ovf_sticky=%b required 01", ovf_sticky);
        end
        ovf_clr = 2'b01;
        @(negedge clk);
        ovf_clr = 2'b00;
        checks++;
        if (ovf_sticky !== 2'b00) begin
            errors++; $display("FAIL sticky_clear: ovf_sticky=%b required 00", ovf_sticky);
        end
`else
        checks++;
        if (ovf_sticky !== 2'b00) begin
            errors++; $display("FAIL sticky_disabled: ovf_sticky=%b required 00", ovf_sticky);
        end
        ovf_clr = 2'b11;
        @(negedge clk);
        ovf_clr = 2'b00;
        checks++;
        if (ovf_sticky !== 2'b00) begin
            errors++; $display("FAIL sticky_disabled_clr: ovf_sticky=%b required 00", ovf_sticky);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_simultaneous();
        test_illegal_and_not();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_sticky();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
